// File: rtl/uart_cmd_receiver_pkg.sv
// Shared definitions for the UART SUMP command receiver.
// Contents: the FSM state encodings for the byte receiver and the command
// assembler, the SUMP long-command marker bit, the long-command argument
// length, and a helper that classifies an opcode byte.
package uart_cmd_receiver_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_BITS  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        CMD_OPCODE = 2'd0,
        CMD_ARG    = 2'd1,
        CMD_EXEC   = 2'd2
    } cmd_state_t;

    // An opcode with this bit set is followed by a 32-bit argument.
    localparam int SUMP_LONG_BIT  = 7;
    localparam int LONG_ARG_BYTES = 4;

    function automatic logic is_long_cmd(input logic [7:0] opcode);
        return opcode[SUMP_LONG_BIT];
    endfunction

endpackage

// File: rtl/uart_cmd_receiver_if.sv
// Host-link signal bundle for uart_cmd_receiver.
//   rx           : synchronized UART line, idles high
//   transmitting : transmitter busy, holds off command execution
//   op, data     : last completed command
//   execute      : one-cycle completion strobe
// The slave modport is the receiver; the master modport is the side that
// drives the line and consumes commands.
interface uart_cmd_receiver_if;
    logic        rx;
    logic        transmitting;
    logic [7:0]  op;
    logic [31:0] data;
    logic        execute;

    modport master (
        output rx,
        output transmitting,
        input  op,
        input  data,
        input  execute
    );

    modport slave (
        input  rx,
        input  transmitting,
        output op,
        output data,
        output execute
    );
endinterface

// File: rtl/uart_cmd_receiver_byte_rx.sv
// 8N1 UART byte receiver.
//   clock      : system clock
//   extReset   : asynchronous active-high reset
//   rx         : synchronized serial input, idles high
//   byte_valid : one-cycle pulse when a byte with a good stop bit arrives
//   byte_data  : the received byte, held until the next good byte
// Bits are sampled at their centres, counted from the middle of the start
// bit. The receiver re-arms at the stop-bit centre so a start bit that
// immediately follows the stop bit is not missed.
module uart_byte_rx
    import uart_cmd_receiver_pkg::*;
#(
    parameter int BITLENGTH = 868
) (
    input  logic       clock,
    input  logic       extReset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data
);

    localparam int HALFBIT = BITLENGTH / 2;
    localparam int CNT_W   = $clog2(BITLENGTH + 1);

    rx_state_t        state_r;
    rx_state_t        next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       shift_r;
    logic             byte_valid_r;
    logic [7:0]       byte_data_r;

    logic half_hit_s;
    logic full_hit_s;
    logic cnt_clr_s;
    logic bit_clr_s;
    logic shift_en_s;
    logic valid_set_s;

    assign half_hit_s = (cnt_r == CNT_W'(HALFBIT - 1));
    assign full_hit_s = (cnt_r == CNT_W'(BITLENGTH - 1));

    // State register.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state_r <= RX_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            RX_IDLE: begin
                if (!rx) next_state_s = RX_START;
                else     next_state_s = RX_IDLE;
            end
            RX_START: begin
                // A start bit that is high again at its centre was a glitch.
                if (half_hit_s) next_state_s = rx ? RX_IDLE : RX_BITS;
                else            next_state_s = RX_START;
            end
            RX_BITS: begin
                if (full_hit_s && (bit_idx_r == 3'd7)) next_state_s = RX_STOP;
                else                                  next_state_s = RX_BITS;
            end
            RX_STOP: begin
                if (full_hit_s) next_state_s = RX_IDLE;
                else            next_state_s = RX_STOP;
            end
            default: next_state_s = RX_IDLE;
        endcase
    end

    // Control strobes for the datapath, decoded from the current state.
    always_comb begin
        cnt_clr_s   = 1'b0;
        bit_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        valid_set_s = 1'b0;
        case (state_r)
            RX_IDLE: begin
                cnt_clr_s = 1'b1;
                bit_clr_s = 1'b1;
            end
            RX_START: begin
                cnt_clr_s = half_hit_s;
            end
            RX_BITS: begin
                cnt_clr_s  = full_hit_s;
                shift_en_s = full_hit_s;
            end
            RX_STOP: begin
                cnt_clr_s   = full_hit_s;
                valid_set_s = full_hit_s & rx;
            end
            default: begin
                cnt_clr_s = 1'b1;
                bit_clr_s = 1'b1;
            end
        endcase
    end

    // Bit-timing counter, bit index, shift register and registered outputs.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            cnt_r        <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
        end else begin
            cnt_r <= cnt_clr_s ? '0 : cnt_r + CNT_W'(1);
            if (bit_clr_s) begin
                bit_idx_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            // LSB arrives first, so shift in from the top.
            if (shift_en_s) begin
                shift_r <= {rx, shift_r[7:1]};
            end
            byte_valid_r <= valid_set_s;
            if (valid_set_s) begin
                byte_data_r <= shift_r;
            end
        end
    end

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;

endmodule

// File: rtl/uart_cmd_receiver.sv
// SUMP command front end: UART bytes in, op/data/execute out.
//   clock    : system clock
//   extReset : asynchronous active-high reset
//   bus      : slave side of uart_cmd_receiver_if (rx, transmitting in;
//              op, data, execute out)
// A byte with bit 7 clear is a complete short command; with bit 7 set it is
// followed by four argument bytes, least significant first. Completed
// commands wait while the transmitter is busy. A long command stalled for
// TIMEOUT_BYTES byte-times is abandoned.
module uart_cmd_receiver
    import uart_cmd_receiver_pkg::*;
#(
    parameter int FREQ          = 100000000,
    parameter int RATE          = 115200,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic                clock,
    input  logic                extReset,
    uart_cmd_receiver_if.slave  bus
);

    localparam int BITLENGTH     = FREQ / RATE;
    localparam int TIMEOUT_LIMIT = TIMEOUT_BYTES * 10 * BITLENGTH;
    localparam int TO_W          = $clog2(TIMEOUT_LIMIT + 1);

    logic       byte_valid_s;
    logic [7:0] byte_data_s;

    cmd_state_t      state_r;
    cmd_state_t      next_state_s;
    logic [7:0]      pend_op_r;
    logic [31:0]     pend_data_r;
    logic            pend_long_r;
    logic [1:0]      arg_idx_r;
    logic [TO_W-1:0] timeout_cnt_r;
    logic [7:0]      op_r;
    logic [31:0]     data_r;
    logic            execute_r;

    logic timeout_hit_s;
    logic latch_op_s;
    logic store_arg_s;
    logic fire_s;
    logic to_count_s;

    uart_byte_rx #(
        .BITLENGTH (BITLENGTH)
    ) u_byte_rx (
        .clock      (clock),
        .extReset   (extReset),
        .rx         (bus.rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s)
    );

    assign timeout_hit_s = (timeout_cnt_r == TO_W'(TIMEOUT_LIMIT));

    // State register.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            state_r <= CMD_OPCODE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            CMD_OPCODE: begin
                if (byte_valid_s) begin
                    next_state_s = is_long_cmd(byte_data_s) ? CMD_ARG : CMD_EXEC;
                end else begin
                    next_state_s = CMD_OPCODE;
                end
            end
            CMD_ARG: begin
                if (byte_valid_s && (arg_idx_r == 2'(LONG_ARG_BYTES - 1))) begin
                    next_state_s = CMD_EXEC;
                end else if (timeout_hit_s) begin
                    next_state_s = CMD_OPCODE;
                end else begin
                    next_state_s = CMD_ARG;
                end
            end
            CMD_EXEC: begin
                if (!bus.transmitting) next_state_s = CMD_OPCODE;
                else                   next_state_s = CMD_EXEC;
            end
            default: next_state_s = CMD_OPCODE;
        endcase
    end

    // Datapath strobes; bytes arriving in CMD_EXEC match no strobe and are dropped.
    always_comb begin
        latch_op_s  = 1'b0;
        store_arg_s = 1'b0;
        fire_s      = 1'b0;
        to_count_s  = 1'b0;
        case (state_r)
            CMD_OPCODE: begin
                latch_op_s = byte_valid_s;
            end
            CMD_ARG: begin
                store_arg_s = byte_valid_s;
                to_count_s  = ~byte_valid_s & ~timeout_hit_s;
            end
            CMD_EXEC: begin
                fire_s = ~bus.transmitting;
            end
            default: begin
                fire_s = 1'b0;
            end
        endcase
    end

    // Pending command, idle timer and registered outputs.
    always_ff @(posedge clock or posedge extReset) begin
        if (extReset) begin
            pend_op_r     <= 8'h00;
            pend_data_r   <= 32'h0000_0000;
            pend_long_r   <= 1'b0;
            arg_idx_r     <= 2'd0;
            timeout_cnt_r <= '0;
            op_r          <= 8'h00;
            data_r        <= 32'h0000_0000;
            execute_r     <= 1'b0;
        end else begin
            if (latch_op_s) begin
                pend_op_r   <= byte_data_s;
                pend_long_r <= is_long_cmd(byte_data_s);
                arg_idx_r   <= 2'd0;
            end else if (store_arg_s) begin
                pend_data_r[{arg_idx_r, 3'b000} +: 8] <= byte_data_s;
                arg_idx_r                             <= arg_idx_r + 2'd1;
            end
            // Counter only runs while waiting for argument bytes.
            timeout_cnt_r <= to_count_s ? timeout_cnt_r + TO_W'(1) : '0;
            execute_r     <= fire_s;
            if (fire_s) begin
                op_r <= pend_op_r;
                // Short commands leave the previous argument visible.
                if (pend_long_r) begin
                    data_r <= pend_data_r;
                end
            end
        end
    end

    assign bus.op      = op_r;
    assign bus.data    = data_r;
    assign bus.execute = execute_r;

endmodule
